power_ctrl: RTL and testbench

POWER_CTRL -- requirements
Module: power_ctrl

---
 rtl/hood_pkg.sv | 28 ++
 rtl/power_ctrl_if.sv | 23 ++
 rtl/btn_debounce.sv | 58 +++++
 rtl/power_ctrl.sv | 141 ++++++++++++++
 tb/tb_power_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/hood_pkg.sv
// Shared types and default timing constants for the hood power controller.
// State encoding, timer widths and small state-class helpers live here.
package hood_pkg;

    localparam int unsigned ONE_SECOND_DEF      = 100_000_000;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int unsigned GESTURE_SEC_DEF     = 5;
    localparam int unsigned LONG_PRESS_SEC_DEF  = 3;

    localparam int unsigned SEC_W = 3;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_ON       = 3'd1,
        ST_GEST_ON  = 3'd2,
        ST_GEST_OFF = 3'd3,
        ST_HOLD     = 3'd4
    } state_e;

    function automatic logic is_powered(state_e s);
        return (s == ST_ON) || (s == ST_GEST_OFF) || (s == ST_HOLD);
    endfunction

    function automatic logic is_gesture(state_e s);
        return (s == ST_GEST_ON) || (s == ST_GEST_OFF);
    endfunction

endpackage

// File: rtl/power_ctrl_if.sv
// Key inputs and status outputs of the hood power controller.
// The master side drives the raw keys, the slave side reports status.
interface power_ctrl_if;
    import hood_pkg::*;

    logic             power_btn;
    logic             left_btn;
    logic             right_btn;
    logic             power_state;
    logic [SEC_W-1:0] gesture_sec_left;
    logic             hold_active;

    modport master (
        output power_btn, left_btn, right_btn,
        input  power_state, gesture_sec_left, hold_active
    );

    modport slave (
        input  power_btn, left_btn, right_btn,
        output power_state, gesture_sec_left, hold_active
    );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counting debouncer for one raw key.
// Emits the stable level and a one-cycle pulse after each stable rise.
module btn_debounce
    import hood_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic stable_o,
    output logic press_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count cycles of disagreement; flip the stable value on the last one
    always_comb begin
        stable_d = stable_q;
        press_d  = 1'b0;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                press_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer, debounce counter and pulse registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign press_o  = press_q;

endmodule

// File: rtl/power_ctrl.sv
// Hood power FSM: power key toggles with long-press off, plus
// left/right gesture windows that switch power after a confirming key.
module power_ctrl
    import hood_pkg::*;
#(
    parameter int unsigned ONE_SECOND      = ONE_SECOND_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned GESTURE_SEC     = GESTURE_SEC_DEF,
    parameter int unsigned LONG_PRESS_SEC  = LONG_PRESS_SEC_DEF
) (
    input  logic         clk,
    input  logic         reset,
    power_ctrl_if.slave  hood
);

    localparam int unsigned CYC_W = (ONE_SECOND > 1) ? $clog2(ONE_SECOND) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(ONE_SECOND - 1);

    logic pwr_press, pwr_lvl;
    logic left_press, left_lvl;
    logic right_press, right_lvl;
    logic unused_lvl;

    state_e           state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic             power_q, power_d;
    logic             hold_c;
    logic [SEC_W-1:0] gsl_c;
    logic             timeout;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pwr (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (hood.power_btn),
        .stable_o(pwr_lvl),
        .press_o (pwr_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (hood.left_btn),
        .stable_o(left_lvl),
        .press_o (left_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (hood.right_btn),
        .stable_o(right_lvl),
        .press_o (right_press)
    );

    // Gesture keys only matter as press pulses
    assign unused_lvl = left_lvl ^ right_lvl;

    // Last cycle of the final second of the running window
    assign timeout = (sec_q == SEC_W'(1)) && (cyc_q == CYC_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_OFF;
        else        state_q <= state_d;
    end

    // Next state: power beats left beats right, presses beat timeouts
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_OFF: begin
                if (pwr_press)       state_d = ST_ON;
                else if (left_press) state_d = ST_GEST_ON;
            end
            ST_GEST_ON: begin
                if (pwr_press)        state_d = ST_ON;
                else if (right_press) state_d = ST_ON;
                else if (timeout)     state_d = ST_OFF;
            end
            ST_ON: begin
                if (pwr_press)        state_d = ST_HOLD;
                else if (right_press) state_d = ST_GEST_OFF;
            end
            ST_GEST_OFF: begin
                if (pwr_press)       state_d = ST_HOLD;
                else if (left_press) state_d = ST_OFF;
                else if (timeout)    state_d = ST_ON;
            end
            ST_HOLD: begin
                if (!pwr_lvl)     state_d = ST_ON;
                else if (timeout) state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase
    end

    // Outputs: power level follows the next state so it lands with it
    always_comb begin
        power_d = is_powered(state_d);
        hold_c  = (state_q == ST_HOLD);
        gsl_c   = is_gesture(state_q) ? sec_q : '0;
    end

    // Window timer, reloaded on every state change
    always_comb begin
        cyc_d = cyc_q;
        sec_d = sec_q;
        if (state_d != state_q) begin
            cyc_d = '0;
            if (is_gesture(state_d))      sec_d = SEC_W'(GESTURE_SEC);
            else if (state_d == ST_HOLD)  sec_d = SEC_W'(LONG_PRESS_SEC);
            else                          sec_d = '0;
        end else if (sec_q != '0) begin
            if (cyc_q == CYC_LAST) begin
                cyc_d = '0;
                sec_d = sec_q - 1'b1;
            end else begin
                cyc_d = cyc_q + 1'b1;
            end
        end
    end

    // Timer and registered power level
    always_ff @(posedge clk) begin
        if (!reset) begin
            cyc_q   <= '0;
            sec_q   <= '0;
            power_q <= 1'b0;
        end else begin
            cyc_q   <= cyc_d;
            sec_q   <= sec_d;
            power_q <= power_d;
        end
    end

    assign hood.power_state      = power_q;
    assign hood.hold_active      = hold_c;
    assign hood.gesture_sec_left = gsl_c;

endmodule

// File: tb/tb_power_ctrl.sv
// Scoreboard bench for power_ctrl with shortened timing constants.
// Expected output values are queued with their due cycle as keys are driven.
module tb_power_ctrl;
    import hood_pkg::*;

    localparam int OS  = 10;
    localparam int DB  = 4;
    localparam int GS  = 5;
    localparam int LP  = 3;
    localparam int LAT = 2 + DB + 1;

    localparam int SIG_PWR  = 0;
    localparam int SIG_GSL  = 1;
    localparam int SIG_HOLD = 2;

    localparam logic [2:0] K_P = 3'b100;
    localparam logic [2:0] K_L = 3'b010;
    localparam logic [2:0] K_R = 3'b001;

    typedef struct packed {
        int when;
        int sig;
        int val;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   n_run = 0;
    int   n_fail = 0;

    exp_t  sb[$];
    string sb_tag[$];

    exp_t  m_e;
    string m_t;
    int    m_got;

    power_ctrl_if hif();

    power_ctrl #(
        .ONE_SECOND     (OS),
        .DEBOUNCE_CYCLES(DB),
        .GESTURE_SEC    (GS),
        .LONG_PRESS_SEC (LP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .hood (hif.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_at(input int dt, input string tag,
                             input int sig, input int val);
        exp_t e;
        e.when = cyc + dt;
        e.sig  = sig;
        e.val  = val;
        sb.push_back(e);
        sb_tag.push_back(tag);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_keys(input logic [2:0] m);
        hif.power_btn = m[2];
        hif.left_btn  = m[1];
        hif.right_btn = m[0];
    endtask

    task automatic hold_keys(input logic [2:0] m, input int n);
        set_keys(m);
        wait_n(n);
        set_keys(3'b000);
    endtask

    // ON -> GEST_OFF -> OFF by right then left
    task automatic go_off(input string tag);
        expect_at(LAT + 20, tag, SIG_PWR, 0);
        hold_keys(K_R, 8);
        wait_n(12);
        hold_keys(K_L, 8);
        wait_n(20);
    endtask

    // Compare every due expectation against the DUT mid-cycle
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].when <= cyc) begin
            m_e = sb.pop_front();
            m_t = sb_tag.pop_front();
            case (m_e.sig)
                SIG_PWR:  m_got = int'(hif.power_state);
                SIG_GSL:  m_got = int'(hif.gesture_sec_left);
                default:  m_got = int'(hif.hold_active);
            endcase
            chk(m_t, m_got, m_e.val);
        end
    end

    initial begin
        set_keys(3'b000);
        reset = 1'b0;
        wait_n(3);
        reset = 1'b1;
        expect_at(0, "rst_pwr", SIG_PWR, 0);
        expect_at(0, "rst_gsl", SIG_GSL, 0);
        expect_at(0, "rst_hold", SIG_HOLD, 0);
        wait_n(5);

        // 3-cycle glitch is filtered
        expect_at(LAT + 1, "glitch_a", SIG_PWR, 0);
        expect_at(LAT + 5, "glitch_b", SIG_PWR, 0);
        hold_keys(K_P, 3);
        wait_n(15);

        // Short power press from OFF
        expect_at(LAT - 1, "on_early", SIG_PWR, 0);
        expect_at(LAT, "on_pwr", SIG_PWR, 1);
        expect_at(LAT, "on_hold", SIG_HOLD, 0);
        hold_keys(K_P, 8);
        wait_n(12);

        // Right alone from ON times out back to ON
        expect_at(LAT, "goff_pwr", SIG_PWR, 1);
        expect_at(LAT, "goff_gsl5", SIG_GSL, 5);
        expect_at(LAT + OS, "goff_gsl4", SIG_GSL, 4);
        expect_at(LAT + GS * OS - 1, "goff_gsl1", SIG_GSL, 1);
        expect_at(LAT + GS * OS, "goff_to_gsl", SIG_GSL, 0);
        expect_at(LAT + GS * OS, "goff_to_pwr", SIG_PWR, 1);
        hold_keys(K_R, 8);
        wait_n(60);

        // Right then left from ON powers off
        expect_at(LAT + 19, "rl_pre", SIG_PWR, 1);
        expect_at(LAT + 20, "rl_pwr", SIG_PWR, 0);
        expect_at(LAT + 20, "rl_gsl", SIG_GSL, 0);
        hold_keys(K_R, 8);
        wait_n(12);
        hold_keys(K_L, 8);
        wait_n(20);

        // Left alone from OFF; repeated left must not reload
        expect_at(LAT, "gon_pwr", SIG_PWR, 0);
        expect_at(LAT, "gon_gsl5", SIG_GSL, 5);
        expect_at(LAT + GS * OS - 1, "gon_gsl1", SIG_GSL, 1);
        expect_at(LAT + GS * OS, "gon_to_gsl", SIG_GSL, 0);
        expect_at(LAT + GS * OS, "gon_to_pwr", SIG_PWR, 0);
        hold_keys(K_L, 8);
        wait_n(12);
        hold_keys(K_L, 8);
        wait_n(40);

        // Left then right from OFF powers on
        expect_at(LAT, "lr_gsl5", SIG_GSL, 5);
        expect_at(LAT + OS, "lr_gsl4", SIG_GSL, 4);
        expect_at(LAT + 19, "lr_pre", SIG_PWR, 0);
        expect_at(LAT + 20, "lr_pwr", SIG_PWR, 1);
        expect_at(LAT + 20, "lr_gsl0", SIG_GSL, 0);
        hold_keys(K_L, 8);
        wait_n(12);
        hold_keys(K_R, 8);
        wait_n(20);

        // Long press from ON powers off; holding on stays off
        expect_at(LAT - 1, "hold_pre", SIG_HOLD, 0);
        expect_at(LAT, "hold_on", SIG_HOLD, 1);
        expect_at(LAT, "hold_pwr", SIG_PWR, 1);
        expect_at(LAT + LP * OS - 1, "hold_last", SIG_PWR, 1);
        expect_at(LAT + LP * OS, "hold_exp_pwr", SIG_PWR, 0);
        expect_at(LAT + LP * OS, "hold_exp_hold", SIG_HOLD, 0);
        expect_at(60, "held_off", SIG_PWR, 0);
        set_keys(K_P);
        wait_n(60);
        set_keys(3'b000);
        expect_at(10, "released_off", SIG_PWR, 0);
        wait_n(20);
        expect_at(LAT, "repress_on", SIG_PWR, 1);
        hold_keys(K_P, 8);
        wait_n(12);

        // Early release in HOLD returns to ON
        expect_at(LAT, "hr_hold", SIG_HOLD, 1);
        expect_at(LAT + 14, "hr_hold_pre", SIG_HOLD, 1);
        expect_at(LAT + 15, "hr_rel_hold", SIG_HOLD, 0);
        expect_at(LAT + 15, "hr_rel_pwr", SIG_PWR, 1);
        expect_at(LAT + LP * OS + 5, "hr_stay_on", SIG_PWR, 1);
        hold_keys(K_P, 15);
        wait_n(40);

        // Coincident power and left in OFF goes to ON
        go_off("off_a");
        expect_at(LAT, "coin_pwr", SIG_PWR, 1);
        expect_at(LAT, "coin_gsl", SIG_GSL, 0);
        hold_keys(K_P | K_L, 8);
        wait_n(12);

        // Reset pulse at 3 s left aborts the window
        go_off("off_b");
        expect_at(LAT, "rst_gon", SIG_GSL, 5);
        expect_at(30, "rst_gsl3", SIG_GSL, 3);
        expect_at(31, "rstw_gsl", SIG_GSL, 0);
        expect_at(31, "rstw_pwr", SIG_PWR, 0);
        expect_at(31, "rstw_hold", SIG_HOLD, 0);
        expect_at(60, "rstw_after", SIG_GSL, 0);
        hold_keys(K_L, 8);
        wait_n(22);
        reset = 1'b0;
        wait_n(1);
        reset = 1'b1;
        wait_n(35);

        for (int i = 0; i < 100 && sb.size() > 0; i++) wait_n(1);
        chk("drain", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
